manchester_decoder_hqii: RTL and testbench

//  Receive side of the HaveQuick II TOD serial link. Samples a Manchester II biphase line, qualifies the
//  all-ones preamble and recovers the 112-bit frame, which is sent LSB first. Frame bits [95:0] are the time

---
 rtl/hqii_pkg.sv | 10 +
 rtl/manch_symbol_sampler.sv | 50 +++++
 rtl/manchester_decoder_hqii.sv | 101 ++++++++++
 tb/tb_manchester_decoder_hqii.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hqii_pkg.sv
// hqii_pkg: shared HaveQuick II TOD link types and constants (decoder and encoder).
package hqii_pkg;
    typedef enum logic [1:0] {HUNT, PREAMBLE, MESSAGE, CHECK} hqii_state_e;
    localparam int          HQII_BIT_CLKS      = 60000;
    localparam int          HQII_PREAMBLE_BITS = 400;
    localparam int          HQII_MSG_BITS      = 112;
    localparam int          HQII_TIME_BITS     = 96;
    localparam int          HQII_IDLE_BITS     = 2;
    localparam logic [15:0] HQII_SYNC_WORD     = 16'hA5C3;
endpackage

// File: rtl/manch_symbol_sampler.sv
// manch_symbol_sampler: line synchronizer, edge detect, mid-bit resync of bit_cnt and half-symbol sampling.
module manch_symbol_sampler
    import hqii_pkg::*;
#(
    parameter int BIT_CLKS  = HQII_BIT_CLKS,
    parameter int TOL_CLKS  = BIT_CLKS / 8,
    parameter int IDLE_BITS = HQII_IDLE_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic manch_in,
    input  logic hunt,
    output logic start,
    output logic sym_valid,
    output logic sym_bit,
    output logic sym_viol,
    output logic no_edge_timeout
);
    localparam int            BW       = $clog2(BIT_CLKS);
    localparam int            IW       = $clog2((IDLE_BITS + 2) * BIT_CLKS);
    localparam logic [IW-1:0] QUIET_MAX = IW'((IDLE_BITS + 2) * BIT_CLKS - 1);
    logic [3:0]    sync;
    logic [BW-1:0] bit_cnt;
    logic [IW-1:0] quiet_cnt;
    logic          h_smp, l_smp, edge_det, mid_edge;
    // sync[1:0] is the synchronizer, sync[3:2] the two-stage edge detector
    assign edge_det        = sync[2] ^ sync[3];
    assign mid_edge        = !hunt && edge_det && bit_cnt >= BW'(BIT_CLKS / 2 - TOL_CLKS)
                             && bit_cnt <= BW'(BIT_CLKS / 2 + TOL_CLKS);
    assign start           = hunt && edge_det && quiet_cnt >= IW'(IDLE_BITS * BIT_CLKS);
    assign sym_valid       = !hunt && bit_cnt == BW'(BIT_CLKS - 1);
    assign sym_bit         = h_smp & ~l_smp;
    assign sym_viol        = h_smp == l_smp;
    assign no_edge_timeout = !hunt && quiet_cnt > IW'(3 * BIT_CLKS / 2);
    // the arming edge is mid-bit, so the level just before it is the first half of symbol one
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            sync      <= '0;
            bit_cnt   <= '0;
            quiet_cnt <= '0;
            h_smp     <= 1'b0;
            l_smp     <= 1'b0;
        end else begin
            sync      <= {sync[2:0], manch_in};
            quiet_cnt <= (hunt ? edge_det : mid_edge) ? '0 : quiet_cnt + IW'(quiet_cnt != QUIET_MAX);
            bit_cnt   <= (start || mid_edge) ? BW'(BIT_CLKS / 2 + 1) : (hunt || sym_valid) ? '0 : bit_cnt + BW'(1);
            h_smp     <= start ? sync[3] : (!hunt && bit_cnt == BW'(BIT_CLKS / 4)) ? sync[2] : h_smp;
            l_smp     <= (!hunt && bit_cnt == BW'(3 * BIT_CLKS / 4)) ? sync[2] : l_smp;
        end
endmodule

// File: rtl/manchester_decoder_hqii.sv
// manchester_decoder_hqii: HaveQuick II TOD receiver; qualifies the preamble, collects the 112-bit frame
// and publishes the 96-bit time message when the sync word matches.
module manchester_decoder_hqii
    import hqii_pkg::*;
#(
    parameter int          BIT_CLKS      = HQII_BIT_CLKS,
    parameter int          TOL_CLKS      = BIT_CLKS / 8,
    parameter int          PREAMBLE_BITS = HQII_PREAMBLE_BITS,
    parameter int          IDLE_BITS     = HQII_IDLE_BITS,
    parameter logic [15:0] SYNC_WORD     = HQII_SYNC_WORD
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      manch_in,
    output logic [HQII_TIME_BITS-1:0] time_msg,
    output logic                      msg_valid,
    output logic                      sync_err,
    output logic                      code_err,
    output logic                      busy
);
    localparam int PW = $clog2(PREAMBLE_BITS + 1);
    localparam int MW = $clog2(HQII_MSG_BITS + 1);
    hqii_state_e              state, state_n;
    logic [PW-1:0]            pre_cnt, pre_n;
    logic [MW-1:0]            msg_cnt, msg_n;
    logic [HQII_MSG_BITS-1:0] shift;
    logic start, sym_valid, sym_bit, sym_viol, no_edge_timeout, wr, ok, bad_sync, bad_code;

    manch_symbol_sampler #(.BIT_CLKS(BIT_CLKS), .TOL_CLKS(TOL_CLKS), .IDLE_BITS(IDLE_BITS)) u_sampler (
        .clk(clk), .reset(reset), .manch_in(manch_in), .hunt(state == HUNT), .start(start),
        .sym_valid(sym_valid), .sym_bit(sym_bit), .sym_viol(sym_viol), .no_edge_timeout(no_edge_timeout)
    );

    assign busy = state != HUNT;

    always_comb begin
        state_n  = state;
        pre_n    = pre_cnt;
        msg_n    = msg_cnt;
        wr       = 1'b0;
        ok       = 1'b0;
        bad_sync = 1'b0;
        bad_code = 1'b0;
        case (state)
            HUNT: begin
                pre_n = '0;
                msg_n = '0;
                if (start) state_n = PREAMBLE;
            end
            PREAMBLE:
                if (no_edge_timeout || (sym_valid && (sym_viol || !sym_bit))) begin
                    bad_code = 1'b1;
                    state_n  = HUNT;
                end else if (sym_valid) begin
                    pre_n = pre_cnt + PW'(1);
                    if (pre_n == PW'(PREAMBLE_BITS)) state_n = MESSAGE;
                end
            MESSAGE:
                if (no_edge_timeout || (sym_valid && sym_viol)) begin
                    bad_code = 1'b1;
                    state_n  = HUNT;
                end else if (sym_valid) begin
                    wr    = 1'b1;
                    msg_n = msg_cnt + MW'(1);
                    if (msg_n == MW'(HQII_MSG_BITS)) state_n = CHECK;
                end
            CHECK: begin
                ok       = shift[HQII_MSG_BITS-1 -: 16] == SYNC_WORD;
                bad_sync = !ok;
                state_n  = HUNT;
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state   <= HUNT;
            pre_cnt <= '0;
            msg_cnt <= '0;
        end else begin
            state   <= state_n;
            pre_cnt <= pre_n;
            msg_cnt <= msg_n;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            shift     <= '0;
            time_msg  <= '0;
            msg_valid <= 1'b0;
            sync_err  <= 1'b0;
            code_err  <= 1'b0;
        end else begin
            if (wr) shift[msg_cnt] <= sym_bit;
            if (ok) time_msg <= shift[HQII_TIME_BITS-1:0];
            msg_valid <= ok;
            sync_err  <= bad_sync;
            code_err  <= bad_code;
        end
endmodule

// File: tb/tb_manchester_decoder_hqii.sv
// tb_manchester_decoder_hqii: drives Manchester frames (directed and random) and checks outcomes against a frame-level model.
module tb_manchester_decoder_hqii;
    localparam int          B  = 16;
    localparam int          P  = 8;
    localparam logic [15:0] SW = 16'hA5C3;
    localparam int VALID = 0, SYNC = 1, CODE = 2;

    logic        clk = 1'b0, reset = 1'b0, manch_in = 1'b1;
    logic [95:0] time_msg;
    logic        msg_valid, sync_err, code_err, busy;
    int          checks = 0, passed = 0;
    int          n_valid = 0, n_sync = 0, n_code = 0, n_clash = 0, n_fall = 0;
    logic        prev_busy = 1'b0;
    logic [95:0] model_time = '0;

    manchester_decoder_hqii #(.BIT_CLKS(B), .TOL_CLKS(2), .PREAMBLE_BITS(P), .IDLE_BITS(2), .SYNC_WORD(SW)) dut (
        .clk(clk), .reset(reset), .manch_in(manch_in), .time_msg(time_msg),
        .msg_valid(msg_valid), .sync_err(sync_err), .code_err(code_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // strobe tally; busy falling with msg_valid is counted separately
    always @(negedge clk) begin
        n_valid   <= n_valid + int'(msg_valid);
        n_sync    <= n_sync + int'(sync_err);
        n_code    <= n_code + int'(code_err);
        n_clash   <= n_clash + int'(int'(msg_valid) + int'(sync_err) + int'(code_err) > 1);
        n_fall    <= n_fall + int'(msg_valid && prev_busy && !busy);
        prev_busy <= busy;
    end

    // frame-level outcome: any broken symbol is a code error, else the sync word decides
    function automatic int predict(input logic [111:0] f, input int bad_pre, input int bad_msg);
        if ((bad_pre >= 0 && bad_pre < P) || (bad_msg >= 0 && bad_msg < 112)) return CODE;
        return (f[111:96] == SW) ? VALID : SYNC;
    endfunction

    function automatic logic [111:0] rand_frame(input logic [15:0] sw);
        return {sw, $urandom, $urandom, $urandom};
    endfunction

    task automatic hold(input logic lvl, input int n);
        manch_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic sym(input logic b, input int len);
        manch_in = b;
        repeat (len / 2) @(negedge clk);
        manch_in = ~b;
        repeat (len - len / 2) @(negedge clk);
    endtask

    // idle line is high; returns with reset still asserted when rst_at is hit
    task automatic send_frame(input logic [111:0] f, input int bad_pre, input int bad_msg, input int rst_at, input bit drift);
        int k = 0;
        int len;
        for (int i = 0; i < P; i++) begin
            len = drift ? 15 + 2 * (k % 2) : B;
            k++;
            if (i == bad_pre) begin
                sym(1'b0, B);
                hold(1'b1, 3 * B);
                return;
            end
            sym(1'b1, len);
        end
        for (int i = 0; i < 112; i++) begin
            len = drift ? 15 + 2 * (k % 2) : B;
            k++;
            if (i == rst_at) begin
                reset = 1'b0;
                manch_in = 1'b1;
                repeat (3) @(negedge clk);
                return;
            end
            if (i == bad_msg) begin
                hold(f[i], B);
                hold(1'b1, 3 * B);
                return;
            end
            sym(f[i], len);
        end
        hold(1'b1, 3 * B);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (time_msg !== 96'h0) $display("FAIL rst_time: got %h want 0", time_msg); else passed++;
        checks++; if (msg_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", msg_valid); else passed++;
        checks++; if (sync_err !== 1'b0) $display("FAIL rst_sync: got %b want 0", sync_err); else passed++;
        checks++; if (code_err !== 1'b0) $display("FAIL rst_code: got %b want 0", code_err); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
        reset = 1'b1;
        hold(1'b1, 40);
    endtask

    task automatic test_frame;
        logic [111:0] f = {16'hA5C3, 96'h0123_4567_89AB_CDEF_0011_2233};
        int v0 = n_valid, s0 = n_sync, c0 = n_code, f0 = n_fall;
        send_frame(f, -1, -1, -1, 1'b0);
        model_time = 96'h0123_4567_89AB_CDEF_0011_2233;
        checks++; if (n_valid - v0 !== 1) $display("FAIL t1_valid: got %0d want 1", n_valid - v0); else passed++;
        checks++; if (n_sync - s0 !== 0) $display("FAIL t1_sync: got %0d want 0", n_sync - s0); else passed++;
        checks++; if (n_code - c0 !== 0) $display("FAIL t1_code: got %0d want 0", n_code - c0); else passed++;
        checks++; if (time_msg !== model_time) $display("FAIL t1_time: got %h want %h", time_msg, model_time); else passed++;
        checks++; if (n_fall - f0 !== 1) $display("FAIL t1_busy_fall: got %0d want 1", n_fall - f0); else passed++;
    endtask

    task automatic test_bad_sync;
        logic [111:0] f = {16'hA5C2, 96'h0123_4567_89AB_CDEF_0011_2233};
        int v0 = n_valid, s0 = n_sync;
        send_frame(f, -1, -1, -1, 1'b0);
        checks++; if (n_sync - s0 !== 1) $display("FAIL t2_sync: got %0d want 1", n_sync - s0); else passed++;
        checks++; if (n_valid - v0 !== 0) $display("FAIL t2_valid: got %0d want 0", n_valid - v0); else passed++;
        checks++; if (time_msg !== model_time) $display("FAIL t2_time: got %h want %h", time_msg, model_time); else passed++;
    endtask

    task automatic test_bad_preamble;
        logic [111:0] f = rand_frame(SW);
        int v0 = n_valid, c0 = n_code;
        send_frame(f, 4, -1, -1, 1'b0);
        checks++; if (n_code - c0 !== 1) $display("FAIL t3_code: got %0d want 1", n_code - c0); else passed++;
        checks++; if (n_valid - v0 !== 0) $display("FAIL t3_valid: got %0d want 0", n_valid - v0); else passed++;
        f = rand_frame(SW);
        v0 = n_valid;
        send_frame(f, -1, -1, -1, 1'b0);
        model_time = f[95:0];
        checks++; if (n_valid - v0 !== 1) $display("FAIL t3_next_valid: got %0d want 1", n_valid - v0); else passed++;
        checks++; if (time_msg !== model_time) $display("FAIL t3_time: got %h want %h", time_msg, model_time); else passed++;
    endtask

    task automatic test_bad_message;
        logic [111:0] f = rand_frame(SW);
        int v0 = n_valid, c0 = n_code;
        f[50] = 1'b1;
        send_frame(f, -1, 50, -1, 1'b0);
        checks++; if (n_code - c0 !== 1) $display("FAIL t4_code: got %0d want 1", n_code - c0); else passed++;
        checks++; if (n_valid - v0 !== 0) $display("FAIL t4_valid: got %0d want 0", n_valid - v0); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL t4_busy: got %b want 0", busy); else passed++;
        checks++; if (time_msg !== model_time) $display("FAIL t4_time: got %h want %h", time_msg, model_time); else passed++;
    endtask

    task automatic test_drift;
        logic [111:0] f = rand_frame(SW);
        int v0 = n_valid, c0 = n_code;
        send_frame(f, -1, -1, -1, 1'b1);
        model_time = f[95:0];
        checks++; if (n_valid - v0 !== 1) $display("FAIL t5_valid: got %0d want 1", n_valid - v0); else passed++;
        checks++; if (n_code - c0 !== 0) $display("FAIL t5_code: got %0d want 0", n_code - c0); else passed++;
        checks++; if (time_msg !== model_time) $display("FAIL t5_time: got %h want %h", time_msg, model_time); else passed++;
    endtask

    task automatic test_reset_mid_frame;
        logic [111:0] f = rand_frame(SW);
        int v0;
        send_frame(f, -1, -1, 60, 1'b0);
        model_time = '0;
        checks++; if (time_msg !== model_time) $display("FAIL t6_rst_time: got %h want 0", time_msg); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL t6_rst_busy: got %b want 0", busy); else passed++;
        checks++; if (msg_valid !== 1'b0) $display("FAIL t6_rst_valid: got %b want 0", msg_valid); else passed++;
        reset = 1'b1;
        hold(1'b1, 3 * B);
        f = rand_frame(SW);
        v0 = n_valid;
        send_frame(f, -1, -1, -1, 1'b0);
        model_time = f[95:0];
        checks++; if (n_valid - v0 !== 1) $display("FAIL t6_valid: got %0d want 1", n_valid - v0); else passed++;
        checks++; if (time_msg !== model_time) $display("FAIL t6_time: got %h want %h", time_msg, model_time); else passed++;
    endtask

    task automatic test_random;
        for (int n = 0; n < 6; n++) begin
            logic [111:0] f = rand_frame($urandom_range(0, 1) ? SW : SW ^ (16'h1 << $urandom_range(0, 15)));
            int bad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 111) : -1;
            int exp = predict(f, -1, bad);
            int v0 = n_valid, s0 = n_sync, c0 = n_code;
            send_frame(f, -1, bad, -1, 1'b0);
            if (exp == VALID) model_time = f[95:0];
            checks++; if (n_valid - v0 !== int'(exp == VALID)) $display("FAIL rnd%0d_valid: got %0d want %0d", n, n_valid - v0, int'(exp == VALID)); else passed++;
            checks++; if (n_sync - s0 !== int'(exp == SYNC)) $display("FAIL rnd%0d_sync: got %0d want %0d", n, n_sync - s0, int'(exp == SYNC)); else passed++;
            checks++; if (n_code - c0 !== int'(exp == CODE)) $display("FAIL rnd%0d_code: got %0d want %0d", n, n_code - c0, int'(exp == CODE)); else passed++;
            checks++; if (time_msg !== model_time) $display("FAIL rnd%0d_time: got %h want %h", n, time_msg, model_time); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_bad_sync;
        test_bad_preamble;
        test_bad_message;
        test_drift;
        test_reset_mid_frame;
        test_random;
        checks++; if (n_clash !== 0) $display("FAIL strobe_exclusive: got %0d overlaps want 0", n_clash); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
